axis_insert_header_mb: RTL and testbench

Parametrised successor of the single-beat header inserter. It prepends a per-packet header of 0 to HDR_BYTES bytes, which may span several beats, to an AXI-Stream payload packet. The payload is byte-realigned behind the header and the output is repacked into full beats. It sits between the packet source and the downstream AXI-Stream sink, with the header supplied on a separate handshake channel.

---
 rtl/axis_insert_header_mb.sv | 195 +++++++++++++++++++
 tb/tb_axis_insert_header_mb.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_insert_header_mb.sv
// Prepends a 0..HDR_BYTES byte header (possibly multi-beat) to an AXI-Stream packet and repacks into full beats.
// Optional packet counter output pkt_cnt is enabled by defining AXIS_HDR_PKT_CNT_EN.
module axis_insert_header_mb #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int HDR_BEATS    = 2,
    parameter int HDR_BYTES    = DATA_BYTE_WD * HDR_BEATS,
    parameter int CNT_WD       = $clog2(HDR_BYTES + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    input  logic                    valid_insert,
    input  logic [HDR_BYTES*8-1:0]  data_insert,
    input  logic [CNT_WD-1:0]       byte_insert_cnt,
    output logic                    ready_insert
`ifdef AXIS_HDR_PKT_CNT_EN
    ,
    output logic [15:0]             pkt_cnt
`endif
);

    localparam int BUF_BYTES = 2 * DATA_BYTE_WD;
    localparam int BUF_W     = BUF_BYTES * 8;
    localparam int HDR_W     = HDR_BYTES * 8;
    localparam int BC_WD     = $clog2(BUF_BYTES + 1);

    localparam logic [BC_WD-1:0]  BEAT_B  = BC_WD'(DATA_BYTE_WD);
    localparam logic [CNT_WD-1:0] BEAT_H  = CNT_WD'(DATA_BYTE_WD);
    localparam logic [CNT_WD-1:0] HDR_MAX = CNT_WD'(HDR_BYTES);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_HDR   = 2'd1;
    localparam logic [1:0] S_PAY   = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    logic [1:0]              state, state_n;
    logic [HDR_W-1:0]        hdr_reg, hdr_n, aligned;
    logic [CNT_WD-1:0]       hdr_left, left_n;
    logic [BUF_W-1:0]        rbuf, rbuf_n, comb_buf;
    logic [BC_WD-1:0]        rbuf_cnt, rcnt_n, comb_cnt, in_cnt;
    logic [DATA_WD-1:0]      in_data, do_n;
    logic [DATA_BYTE_WD-1:0] ko_n;
    logic                    vo_n, lo_n, ready_in_n, ready_insert_n;
    logic                    out_free, accept, have_last;

    always_comb begin
        state_n  = state;
        hdr_n    = hdr_reg;
        left_n   = hdr_left;
        rbuf_n   = rbuf;
        rcnt_n   = rbuf_cnt;
        vo_n     = valid_out;
        do_n     = data_out;
        ko_n     = keep_out;
        lo_n     = last_out;
        aligned  = '0;
        out_free = !valid_out || ready_out;
        accept   = valid_in && ready_in;
        if (valid_out && ready_out) vo_n = 1'b0;

        // Compact the kept payload bytes to the MSB end and count them.
        in_cnt  = '0;
        in_data = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            if (keep_in[DATA_BYTE_WD-1-i]) begin
                in_cnt = in_cnt + BC_WD'(1);
                in_data[DATA_WD-1-8*i -: 8] = data_in[DATA_WD-1-8*i -: 8];
            end
        end

        // Realign buffer: valid bytes left-aligned, new beat appended behind them.
        comb_buf = rbuf & ~({BUF_W{1'b1}} >> {rbuf_cnt, 3'b000});
        comb_cnt = rbuf_cnt;
        if (accept) begin
            comb_buf = comb_buf | ({in_data, {DATA_WD{1'b0}}} >> {rbuf_cnt, 3'b000});
            comb_cnt = rbuf_cnt + in_cnt;
        end
        have_last = (state == S_FLUSH) || (accept && last_in);

        case (state)
            S_IDLE: begin
                if (valid_insert && ready_insert) begin
                    aligned = data_insert << {HDR_MAX - byte_insert_cnt, 3'b000};
                    hdr_n   = aligned;
                    left_n  = byte_insert_cnt;
                    if (byte_insert_cnt >= BEAT_H) begin
                        vo_n   = 1'b1;
                        do_n   = aligned[HDR_W-1 -: DATA_WD];
                        ko_n   = '1;
                        lo_n   = 1'b0;
                        hdr_n  = aligned << DATA_WD;
                        left_n = byte_insert_cnt - BEAT_H;
                    end
                    if (left_n >= BEAT_H) begin
                        state_n = S_HDR;
                    end else begin
                        state_n = S_PAY;
                        rbuf_n  = {hdr_n[HDR_W-1 -: DATA_WD], {DATA_WD{1'b0}}};
                        rcnt_n  = BC_WD'(left_n);
                    end
                end
            end
            S_HDR: begin
                if (out_free) begin
                    vo_n   = 1'b1;
                    do_n   = hdr_reg[HDR_W-1 -: DATA_WD];
                    ko_n   = '1;
                    lo_n   = 1'b0;
                    hdr_n  = hdr_reg << DATA_WD;
                    left_n = hdr_left - BEAT_H;
                    if (left_n < BEAT_H) begin
                        state_n = S_PAY;
                        rbuf_n  = {hdr_n[HDR_W-1 -: DATA_WD], {DATA_WD{1'b0}}};
                        rcnt_n  = BC_WD'(left_n);
                    end
                end
            end
            default: begin
                rbuf_n = comb_buf;
                rcnt_n = comb_cnt;
                if (out_free) begin
                    if (comb_cnt >= BEAT_B) begin
                        vo_n   = 1'b1;
                        do_n   = comb_buf[BUF_W-1 -: DATA_WD];
                        ko_n   = '1;
                        lo_n   = have_last && (comb_cnt == BEAT_B);
                        rbuf_n = comb_buf << DATA_WD;
                        rcnt_n = comb_cnt - BEAT_B;
                    end else if (have_last && comb_cnt != '0) begin
                        vo_n   = 1'b1;
                        do_n   = comb_buf[BUF_W-1 -: DATA_WD];
                        ko_n   = ~({DATA_BYTE_WD{1'b1}} >> comb_cnt);
                        lo_n   = 1'b1;
                        rbuf_n = '0;
                        rcnt_n = '0;
                    end else if (state == S_FLUSH) begin
                        // Buffer empty and the last beat has handshaken (or never existed).
                        state_n = S_IDLE;
                    end
                end
                if (state == S_PAY && have_last) state_n = S_FLUSH;
            end
        endcase

        // Registered ready: only offer a beat the buffer can absorb even if the output stalls.
        ready_in_n     = (state_n == S_PAY) && (rcnt_n <= BEAT_B);
        ready_insert_n = (state_n == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            hdr_reg      <= '0;
            hdr_left     <= '0;
            rbuf         <= '0;
            rbuf_cnt     <= '0;
            valid_out    <= 1'b0;
            data_out     <= '0;
            keep_out     <= '0;
            last_out     <= 1'b0;
            ready_in     <= 1'b0;
            ready_insert <= 1'b0;
        end else begin
            state        <= state_n;
            hdr_reg      <= hdr_n;
            hdr_left     <= left_n;
            rbuf         <= rbuf_n;
            rbuf_cnt     <= rcnt_n;
            valid_out    <= vo_n;
            data_out     <= do_n;
            keep_out     <= ko_n;
            last_out     <= lo_n;
            ready_in     <= ready_in_n;
            ready_insert <= ready_insert_n;
        end
    end

`ifdef AXIS_HDR_PKT_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) pkt_cnt <= '0;
        else if (valid_out && ready_out && last_out) pkt_cnt <= pkt_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_axis_insert_header_mb.sv
// Bench for axis_insert_header_mb: directed vectors, 200 random packets with stalls, and a mid-packet reset.
module tb_axis_insert_header_mb;
    localparam int DW   = 32;
    localparam int BW   = 4;
    localparam int HB   = 8;
    localparam int CW   = 4;
    localparam int NPKT = 220;
    localparam int MAXP = 20;
    localparam int EW   = 1 + BW + DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in, last_in, ready_in;
    logic [DW-1:0] data_in;
    logic [BW-1:0] keep_in;
    logic          valid_out, last_out, ready_out;
    logic [DW-1:0] data_out;
    logic [BW-1:0] keep_out;
    logic          valid_insert, ready_insert;
    logic [HB*8-1:0] data_insert;
    logic [CW-1:0]   byte_insert_cnt;
`ifdef AXIS_HDR_PKT_CNT_EN
    logic [15:0]     pkt_cnt;
`endif

    always #5 clk = ~clk;

    axis_insert_header_mb #(.DATA_WD(DW), .HDR_BEATS(2)) dut (
        .clk(clk), .rst(rst),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
        .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out), .ready_out(ready_out),
        .valid_insert(valid_insert), .data_insert(data_insert), .byte_insert_cnt(byte_insert_cnt),
        .ready_insert(ready_insert)
`ifdef AXIS_HDR_PKT_CNT_EN
        , .pkt_cnt(pkt_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mdl_q[$];

    logic [63:0] p_hdr [NPKT];
    int          p_cnt [NPKT];
    int          p_len [NPKT];
    logic [7:0]  p_pay [NPKT][MAXP];
    int          n_pkts = 0;

    bit rdy_rand = 1'b0;
    bit gaps_en  = 1'b0;
    int bubbles  = 0;
    bit in_pkt   = 1'b0;
    int done_pkts = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Reference: header bytes then payload bytes, chopped into beats of BW bytes.
    function automatic void model(input int p);
        logic [7:0] b[$];
        logic [DW-1:0] d;
        logic [BW-1:0] k;
        mdl_q.delete();
        for (int i = 0; i < p_cnt[p]; i++) b.push_back(p_hdr[p][8*(p_cnt[p]-1-i) +: 8]);
        for (int i = 0; i < p_len[p]; i++) b.push_back(p_pay[p][i]);
        for (int s = 0; s < b.size(); s += BW) begin
            d = '0;
            k = '0;
            for (int j = 0; j < BW; j++) begin
                if (s + j < b.size()) begin
                    d[DW-1-8*j -: 8] = b[s+j];
                    k[BW-1-j] = 1'b1;
                end
            end
            mdl_q.push_back({(s + BW >= b.size()), k, d});
        end
    endfunction

    task automatic new_pkt(input int cnt, input logic [63:0] hdr, input int len, input logic [159:0] pay);
        int p;
        p = n_pkts;
        p_cnt[p] = cnt;
        p_hdr[p] = hdr;
        p_len[p] = len;
        for (int i = 0; i < MAXP; i++) p_pay[p][i] = pay[159-8*i -: 8];
        model(p);
        foreach (mdl_q[i]) exp_q.push_back(mdl_q[i]);
        n_pkts++;
    endtask

    task automatic send_hdr(input int p);
        bit ok;
        if (gaps_en) repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        valid_insert    = 1'b1;
        data_insert     = p_hdr[p];
        byte_insert_cnt = CW'(p_cnt[p]);
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (ready_insert) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_tests++; n_fail++;
            $display("FAIL hdr_timeout: packet %0d got no ready_insert, required within 3000 cycles", p);
        end
        @(posedge clk);
        #1;
        valid_insert = 1'b0;
        data_insert  = {$urandom, $urandom};
        if (ok && p_cnt[p] >= BW) check("first_beat_T+1", {63'd0, valid_out}, 64'd1);
    endtask

    task automatic send_pay(input int p);
        int nb, nlast, idx;
        bit ok;
        nb    = (p_len[p] + BW - 1) / BW;
        nlast = p_len[p] - BW * (nb - 1);
        for (int b = 0; b < nb; b++) begin
            if (gaps_en && $urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
            valid_in = 1'b1;
            for (int j = 0; j < BW; j++) begin
                idx = b * BW + j;
                data_in[DW-1-8*j -: 8] = (idx < p_len[p]) ? p_pay[p][idx] : 8'($urandom);
            end
            last_in = (b == nb - 1);
            keep_in = (b == nb - 1) ? ~(4'hF >> nlast) : 4'hF;
            ok = 1'b0;
            for (int k = 0; k < 3000; k++) begin
                @(negedge clk);
                if (ready_in) begin ok = 1'b1; break; end
            end
            if (!ok) begin
                n_tests++; n_fail++;
                $display("FAIL pay_timeout: packet %0d beat %0d got no ready_in, required within 3000 cycles", p, b);
            end
            @(posedge clk);
            #1;
            valid_in = 1'b0;
            last_in  = 1'b0;
        end
    endtask

    task automatic run_range(input int a, input int b);
        fork
            begin for (int p = a; p < b; p++) send_hdr(p); end
            begin for (int p = a; p < b; p++) send_pay(p); end
        join
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 3000; k++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
        end
        if (exp_q.size() != 0) begin
            n_tests++; n_fail++;
            $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid_out"}, {63'd0, valid_out}, 64'd0);
        check({tag, "_last_out"}, {63'd0, last_out}, 64'd0);
        check({tag, "_data_out"}, {32'd0, data_out}, 64'd0);
        check({tag, "_keep_out"}, {60'd0, keep_out}, 64'd0);
        check({tag, "_ready_in"}, {63'd0, ready_in}, 64'd0);
        check({tag, "_ready_insert"}, {63'd0, ready_insert}, 64'd0);
    endtask

    // Output monitor: every handshake against the expected queue, plus hold-while-stalled.
    logic          prev_stall = 1'b0;
    logic [EW-1:0] prev_beat;
    always @(negedge clk) begin
        logic [EW-1:0] e;
        logic [DW-1:0] m;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("hold_while_stalled", {27'd0, valid_out, last_out, keep_out, data_out}, {27'd0, 1'b1, prev_beat});
            if (in_pkt && !valid_out) bubbles++;
            if (valid_out && ready_out) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_beat: got %h, required no beat", {last_out, keep_out, data_out});
                end else begin
                    e = exp_q.pop_front();
                    m = '0;
                    for (int j = 0; j < BW; j++) if (e[DW+j]) m[8*j +: 8] = 8'hFF;
                    check("out_beat", {27'd0, last_out, keep_out, data_out & m}, {27'd0, e});
                end
                in_pkt = !last_out;
                if (last_out) done_pkts++;
            end
            prev_stall = valid_out && !ready_out;
            prev_beat  = {last_out, keep_out, data_out};
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            ready_out = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
        valid_insert = 1'b0; data_insert = '0; byte_insert_cnt = '0;
        ready_out = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_insert_rise", {63'd0, ready_insert}, 64'd1);

        // Directed vectors with hand-computed beats pinning the model.
        new_pkt(2, 64'hAABB, 8, {64'h1122334455667788, 96'd0});
        check("mdl1_n", mdl_q.size(), 3);
        check("mdl1_b0", {27'd0, mdl_q[0]}, {27'd0, 1'b0, 4'hF, 32'hAABB1122});
        check("mdl1_b1", {27'd0, mdl_q[1]}, {27'd0, 1'b0, 4'hF, 32'h33445566});
        check("mdl1_b2", {27'd0, mdl_q[2]}, {27'd0, 1'b1, 4'hC, 32'h77880000});
        new_pkt(0, 64'hDEAD, 6, {48'h010203040506, 112'd0});
        check("mdl2_n", mdl_q.size(), 2);
        check("mdl2_b1", {27'd0, mdl_q[1]}, {27'd0, 1'b1, 4'hC, 32'h05060000});
        new_pkt(8, 64'h0102030405060708, 1, {8'hA1, 152'd0});
        check("mdl3_n", mdl_q.size(), 3);
        check("mdl3_b0", {27'd0, mdl_q[0]}, {27'd0, 1'b0, 4'hF, 32'h01020304});
        check("mdl3_b2", {27'd0, mdl_q[2]}, {27'd0, 1'b1, 4'h8, 32'hA1000000});
        new_pkt(3, 64'hC1C2C3, 5, {40'hD1D2D3D4E1, 120'd0});
        check("mdl4_n", mdl_q.size(), 2);
        check("mdl4_b1", {27'd0, mdl_q[1]}, {27'd0, 1'b1, 4'hF, 32'hD2D3D4E1});
        run_range(0, 4);
        wait_drain();

        // Streaming packet with no stalls: no output bubbles expected.
        new_pkt(6, 64'h0000A0A1A2A3A4A5, 16, {128'h101112131415161718191A1B1C1D1E1F, 32'd0});
        bubbles = 0;
        run_range(4, 5);
        wait_drain();
        check("no_bubbles", bubbles, 0);

        // Random packets with random stalls on all three channels.
        for (int i = 0; i < 200; i++)
            new_pkt($urandom_range(0, HB), {$urandom, $urandom}, $urandom_range(1, MAXP),
                    {$urandom, $urandom, $urandom, $urandom, $urandom});
        rdy_rand = 1'b1;
        gaps_en  = 1'b1;
        run_range(5, 205);
        wait_drain();
        check("pkts_done", done_pkts, 205);
`ifdef AXIS_HDR_PKT_CNT_EN
        check("pkt_cnt", {48'd0, pkt_cnt}, 64'd205);
`endif

        // Mid-payload reset, then a clean packet.
        rdy_rand = 1'b0;
        gaps_en  = 1'b0;
        @(posedge clk);
        #1;
        new_pkt(2, 64'h5A5A, 12, {96'hB0B1B2B3B4B5B6B7B8B9BABB, 64'd0});
        send_hdr(205);
        valid_in = 1'b1;
        data_in  = 32'hB0B1B2B3;
        keep_in  = 4'hF;
        last_in  = 1'b0;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("midrst");
`ifdef AXIS_HDR_PKT_CNT_EN
        check("pkt_cnt_rst", {48'd0, pkt_cnt}, 64'd0);
`endif
        exp_q.delete();
        in_pkt = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_ready_insert", {63'd0, ready_insert}, 64'd1);
        new_pkt(5, 64'h0000001122334455, 7, {56'h66778899AABBCC, 104'd0});
        new_pkt(8, 64'hF0F1F2F3F4F5F6F7, 9, {72'hE0E1E2E3E4E5E6E7E8, 88'd0});
        run_range(206, 208);
        wait_drain();
        check("exp_empty", exp_q.size(), 0);
`ifdef AXIS_HDR_PKT_CNT_EN
        check("pkt_cnt_after_rst", {48'd0, pkt_cnt}, 64'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
